// File: rtl/pipe_queue_rx.sv
// ---------------------------------------------------------------------------
// pipe_queue_rx
//
// Receive-side decoupling queue for a valid/allow pipeline handshake. Entries
// (payload plus exception flag) are accepted from the upstream stage, kept in
// a circular buffer of DEPTH slots and handed to the next stage in order.
// When nothing is presented the output carries NOP_DATA. Once an excepting
// entry has been accepted, intake is frozen until that entry leaves, so no
// younger work ever sits behind an exception.
//
// Optional feature macro: PIPE_QUEUE_BYPASS_EN
//   When defined, an empty queue forwards the upstream entry combinationally
//   (zero latency). It consumes the entry without storing it if the
//   downstream accepts it in the same cycle.
//
// Ports:
//   aclk       clock
//   aresetn    synchronous active-low reset
//   flush      synchronous clear of all entries and state
//   in_valid   upstream presents an entry
//   in_data    upstream payload
//   in_exc     upstream entry carries an exception
//   in_allow   queue can accept an entry (to upstream allow_in)
//   out_valid  queue presents an entry
//   out_data   head payload, NOP_DATA when out_valid=0
//   out_exc    head exception flag, 0 when out_valid=0
//   out_allow  downstream accepts the head
//   count      current occupancy
// ---------------------------------------------------------------------------
module pipe_queue_rx #(
    parameter int               WIDTH    = 64,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] NOP_DATA = '0
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_exc,
    output logic                     in_allow,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_exc,
    input  logic                     out_allow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] data_mem_q [DEPTH];
    logic             exc_mem_q  [DEPTH];

    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0] count_q,    count_d;
    logic          exc_hold_q, exc_hold_d;

    logic          not_empty;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          push_store;
    logic          pop_store;
    logic          head_exc;

    assign not_empty = (count_q != CW'(0));
    assign head_exc  = exc_mem_q[rd_ptr_q];

`ifdef PIPE_QUEUE_BYPASS_EN
    // Bypass is suppressed during reset as well as flush so the reset output
    // values hold even while upstream already drives valid.
    assign bypass = ~not_empty & in_valid & ~exc_hold_q & ~flush & aresetn;
`else
    assign bypass = 1'b0;
`endif

    // Handshake outputs depend only on registered state (and, in the bypass
    // build, on the upstream inputs); there is no path from out_allow.
    always_comb begin
        in_allow  = (count_q != CW'(DEPTH)) & ~exc_hold_q;
        out_valid = not_empty | bypass;
        out_data  = NOP_DATA;
        out_exc   = 1'b0;
        if (bypass) begin
            out_data = in_data;
            out_exc  = in_exc;
        end else if (not_empty) begin
            out_data = data_mem_q[rd_ptr_q];
            out_exc  = head_exc;
        end
        count = count_q;
    end

    // A bypassed entry taken by the downstream in the same cycle never
    // touches the storage; otherwise push/pop act on the buffer.
    always_comb begin
        push       = in_valid & in_allow;
        pop        = out_valid & out_allow;
        push_store = push & ~(bypass & out_allow);
        pop_store  = pop & not_empty;

        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        exc_hold_d = exc_hold_q;

        if (push_store) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_store) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_store, pop_store})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Setting and clearing cannot collide: a push is only possible while
        // the hold is clear, so no excepting entry is queued at that moment.
        if (push_store & in_exc) begin
            exc_hold_d = 1'b1;
        end else if (pop_store & head_exc) begin
            exc_hold_d = 1'b0;
        end

        if (~aresetn | flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            exc_hold_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        rd_ptr_q   <= rd_ptr_d;
        wr_ptr_q   <= wr_ptr_d;
        count_q    <= count_d;
        exc_hold_q <= exc_hold_d;
    end

    // Payload storage is never cleared; stale slots are hidden by count.
    always_ff @(posedge aclk) begin
        if (push_store & aresetn & ~flush) begin
            data_mem_q[wr_ptr_q] <= in_data;
            exc_mem_q[wr_ptr_q]  <= in_exc;
        end
    end

endmodule

// File: tb/tb_pipe_queue_rx.sv
// ---------------------------------------------------------------------------
// tb_pipe_queue_rx
//
// Self-checking bench for pipe_queue_rx. A queue-based reference model tracks
// the expected contents and exception hold; every cycle the DUT outputs are
// compared against values derived from that model, both for directed
// scenarios and for a randomized run.
// ---------------------------------------------------------------------------
module tb_pipe_queue_rx;

    localparam int               WIDTH    = 64;
    localparam int               DEPTH    = 4;
    localparam logic [WIDTH-1:0] NOP_DATA = 64'hDEAD_BEEF_0BAD_F00D;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             exc;
    } entry_t;

    logic                   aclk;
    logic                   aresetn;
    logic                   flush;
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_exc;
    logic                   in_allow;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic                   out_exc;
    logic                   out_allow;
    logic [$clog2(DEPTH):0] count;

    entry_t model_q[$];
    logic   model_hold;
    int     tests_run;
    int     tests_failed;
    int     max_count;

    pipe_queue_rx #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NOP_DATA (NOP_DATA)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_exc    (in_exc),
        .in_allow  (in_allow),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_exc   (out_exc),
        .out_allow (out_allow),
        .count     (count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_output(input string tag, input logic [WIDTH-1:0] observed,
                                input logic [WIDTH-1:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, compare outputs
    // against the model, then advance the model across the rising edge.
    task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] d, input logic e,
                                  input logic oa, input logic fl, output logic accepted);
        logic             exp_allow;
        logic             exp_valid;
        logic [WIDTH-1:0] exp_data;
        logic             exp_exc;
        logic             byp;
        entry_t           ent;
        entry_t           head;

        in_valid  = v;
        in_data   = d;
        in_exc    = e;
        out_allow = oa;
        flush     = fl;
        #1;

        byp = 1'b0;
`ifdef PIPE_QUEUE_BYPASS_EN
        byp = (model_q.size() == 0) && v && !model_hold && !fl;
`endif
        exp_allow = (model_q.size() < DEPTH) && !model_hold;
        exp_valid = (model_q.size() != 0) || byp;
        exp_data  = NOP_DATA;
        exp_exc   = 1'b0;
        if (byp) begin
            exp_data = d;
            exp_exc  = e;
        end else if (model_q.size() != 0) begin
            exp_data = model_q[0].data;
            exp_exc  = model_q[0].exc;
        end

        check_output("in_allow",  WIDTH'(in_allow),  WIDTH'(exp_allow));
        check_output("out_valid", WIDTH'(out_valid), WIDTH'(exp_valid));
        check_output("out_data",  out_data,          exp_data);
        check_output("out_exc",   WIDTH'(out_exc),   WIDTH'(exp_exc));
        check_output("count",     WIDTH'(count),     WIDTH'(model_q.size()));
        if (int'(count) > max_count) max_count = int'(count);

        accepted = !fl && v && exp_allow;
        @(posedge aclk);
        if (fl) begin
            model_q.delete();
            model_hold = 1'b0;
        end else if (byp && oa) begin
            // Consumed straight through; nothing stored.
        end else begin
            if (exp_valid && oa) begin
                head = model_q.pop_front();
                if (head.exc) model_hold = 1'b0;
            end
            if (accepted) begin
                ent.data = d;
                ent.exc  = e;
                model_q.push_back(ent);
                if (e) model_hold = 1'b1;
            end
        end
        @(negedge aclk);
    endtask

    initial begin
        logic             acc;
        logic [WIDTH-1:0] next_val;
        int               sent;

        tests_run    = 0;
        tests_failed = 0;
        max_count    = 0;
        model_hold   = 1'b0;
        aresetn      = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_exc       = 1'b0;
        out_allow    = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check_output("rst_in_allow",  WIDTH'(in_allow),  WIDTH'(1));
        check_output("rst_out_valid", WIDTH'(out_valid), WIDTH'(0));
        check_output("rst_out_data",  out_data,          NOP_DATA);
        check_output("rst_out_exc",   WIDTH'(out_exc),   WIDTH'(0));
        check_output("rst_count",     WIDTH'(count),     WIDTH'(0));
        @(negedge aclk);

        // Streaming pushes with the downstream always accepting.
        apply_stimulus(1, 64'h11, 0, 1, 0, acc);
        apply_stimulus(1, 64'h22, 0, 1, 0, acc);
        apply_stimulus(1, 64'h33, 0, 1, 0, acc);
        apply_stimulus(0, 64'h0,  0, 1, 0, acc);
        apply_stimulus(0, 64'h0,  0, 1, 0, acc);
        check_output("stream_max_count", WIDTH'(max_count), WIDTH'(1));

        // Fill past capacity with the downstream stalled, then drain.
        next_val = 64'd1;
        sent     = 0;
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(sent < 5, next_val, 0, 0, 0, acc);
            if (acc) begin
                next_val++;
                sent++;
            end
        end
        check_output("full_count", WIDTH'(count), WIDTH'(DEPTH));
        check_output("full_sent",  WIDTH'(sent),  WIDTH'(DEPTH));
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(sent < 5, next_val, 0, 1, 0, acc);
            if (acc) begin
                next_val++;
                sent++;
            end
        end
        check_output("drain_sent", WIDTH'(sent), WIDTH'(5));

        // Flush while partly full, with a push offered in the same cycle.
        for (int i = 0; i < 3; i++) apply_stimulus(1, 64'hA0 + WIDTH'(i), 0, 0, 0, acc);
        apply_stimulus(1, 64'hAF, 0, 1, 1, acc);
        apply_stimulus(0, 64'h0,  0, 0, 0, acc);

        // Exception freeze: A, B(exc), then C held until B leaves.
        apply_stimulus(1, 64'hA, 0, 0, 0, acc);
        apply_stimulus(1, 64'hB, 1, 0, 0, acc);
        for (int i = 0; i < 3; i++) apply_stimulus(1, 64'hC, 0, 0, 0, acc);
        for (int i = 0; i < 5; i++) apply_stimulus(1, 64'hC, 0, 1, 0, acc);
        apply_stimulus(0, 64'h0, 0, 1, 0, acc);

        // Steady push/pop at occupancy two across pointer wrap.
        apply_stimulus(0, 64'h0,   0, 1, 1, acc);
        apply_stimulus(1, 64'h100, 0, 0, 0, acc);
        apply_stimulus(1, 64'h101, 0, 0, 0, acc);
        for (int i = 0; i < 10; i++) apply_stimulus(1, 64'h102 + WIDTH'(i), 0, 1, 0, acc);
        check_output("steady_count", WIDTH'(count), WIDTH'(2));

        // Empty queue with a simultaneous offer and accept.
        apply_stimulus(0, 64'h0,    0, 1, 1, acc);
        apply_stimulus(1, 64'h5A5A, 0, 1, 0, acc);
        apply_stimulus(0, 64'h0,    0, 1, 0, acc);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)),
                           {32'($urandom), 32'($urandom)},
                           $urandom_range(0, 7) == 0,
                           $urandom_range(0, 2) != 0,
                           $urandom_range(0, 40) == 0,
                           acc);
        end

        // Mid-operation reset.
        aresetn = 1'b0;
        apply_stimulus(0, 64'h0, 0, 0, 1, acc);
        aresetn = 1'b1;
        apply_stimulus(0, 64'h0, 0, 0, 0, acc);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
